// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte per request to the
// keyboard (reset 0xFF, LED 0xED + mask, enable 0xF4) using the standard
// host request sequence: inhibit the clock, pull data low for the start bit,
// release the clock, then present bits on each device clock fall.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   tx_data      byte to send
//   tx_valid     request; accepted when tx_valid && tx_ready
//   tx_ready     high only while idle
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull ps2_clk low, 0 = release
//   ps2_data_oe  1 = pull ps2_data low, 0 = release
//   busy         high whenever not idle (lets the top mask the receiver)
//   tx_done      one-cycle pulse: frame ACKed and bus idle again
//   tx_err       one-cycle pulse: NACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int CLK_HZ         = 100000000,
    parameter int INHIBIT_US     = 100,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int          CNT_W          = 21;
    localparam int          INHIBIT_CYCLES = CLK_HZ / 1000000 * INHIBIT_US;
    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RQST,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t state_reg, state_next;

    // -----------------------------------------------------------------------
    // Input synchronizers: bit 0 = clock line, bit 1 = data line. Both lines
    // share the same depth so a sampled data bit lines up with its clock fall.
    // -----------------------------------------------------------------------
    logic [1:0] line_raw;
    logic [1:0] line_sync;

    assign line_raw = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= line_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign line_sync[gi] = sync_reg;
        end
    endgenerate

    logic clk_s;
    logic data_s;
    logic clk_prev_reg;
    logic fall;

    assign clk_s  = line_sync[0];
    assign data_s = line_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= clk_s;
        end
    end

    assign fall = clk_prev_reg & ~clk_s;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;       // inhibit length, then request timeout
    logic [3:0]       bit_cnt_reg;   // device clock falls seen in SHIFT
    logic [7:0]       shreg_reg;
    logic             par_reg;
    logic             data_oe_reg;   // data drive level while the device clocks
    logic             idle_seen_reg; // previous cycle already had an idle bus

    logic in_frame;
    logic timeout;
    logic inhibit_last;
    logic bus_idle;
    logic idle_done;
    logic nack;

    assign in_frame     = (state_reg == S_RQST) || (state_reg == S_SHIFT) ||
                          (state_reg == S_ACK);
    assign timeout      = in_frame && (cnt_reg == TO_LAST);
    assign inhibit_last = (state_reg == S_INHIBIT) && (cnt_reg == INH_LAST);
    assign bus_idle     = clk_s & data_s;
    assign idle_done    = (state_reg == S_WAIT_IDLE) && bus_idle && idle_seen_reg;
    assign nack         = (state_reg == S_ACK) && fall && data_s && !timeout;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; timeout is checked first so it wins over a fall.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (tx_valid) begin
                    state_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inhibit_last) begin
                    state_next = S_RQST;
                end
            end
            S_RQST: begin
                // Start bit is already on the bus; wait for the device in SHIFT.
                if (timeout) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (timeout) begin
                    state_next = S_IDLE;
                end else if (fall && (bit_cnt_reg == 4'd9)) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (timeout) begin
                    state_next = S_IDLE;
                end else if (fall) begin
                    state_next = data_s ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (idle_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tx_ready    = (state_reg == S_IDLE);
        busy        = (state_reg != S_IDLE);
        ps2_clk_oe  = (state_reg == S_INHIBIT);
        // Data goes low in the last inhibit cycle so it is already low when
        // the clock is released; a timeout drops both lines in its own cycle.
        ps2_data_oe = inhibit_last || (in_frame && data_oe_reg && !timeout);
        tx_done     = idle_done;
        tx_err      = timeout || nack;
    end

    // Datapath: counters, shift register and data drive level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            shreg_reg     <= '0;
            par_reg       <= 1'b0;
            data_oe_reg   <= 1'b0;
            idle_seen_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    data_oe_reg   <= 1'b0;
                    idle_seen_reg <= 1'b0;
                    if (tx_valid) begin
                        shreg_reg   <= tx_data;
                        par_reg     <= ~^tx_data;
                        bit_cnt_reg <= '0;
                        cnt_reg     <= '0;
                    end
                end
                S_INHIBIT: begin
                    if (inhibit_last) begin
                        cnt_reg     <= '0;
                        data_oe_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RQST, S_SHIFT, S_ACK: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (timeout) begin
                        data_oe_reg <= 1'b0;
                    end else if (fall && (state_reg == S_SHIFT)) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg < 4'd8) begin
                            data_oe_reg <= ~shreg_reg[0];
                            shreg_reg   <= shreg_reg >> 1;
                        end else if (bit_cnt_reg == 4'd8) begin
                            data_oe_reg <= ~par_reg;
                        end else begin
                            data_oe_reg <= 1'b0;
                        end
                    end else if (state_reg == S_ACK) begin
                        data_oe_reg <= 1'b0;
                    end
                    idle_seen_reg <= 1'b0;
                end
                S_WAIT_IDLE: begin
                    idle_seen_reg <= bus_idle;
                end
                default: begin
                    data_oe_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Bench for ps2_host_tx with a behavioural PS/2 device: the device watches the
// host request, clocks the frame, records the bits it sees and answers with
// ACK or NACK. Expected frames come from the byte value alone (start 0, data
// LSB first, odd parity, stop 1). Scaled parameters keep the run short.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int CLK_HZ         = 10000000;
    localparam int INHIBIT_US     = 100;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int INH_N          = CLK_HZ / 1000000 * INHIBIT_US;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    bit   scramble = 1'b0;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    bit both_seen = 1'b0;

    // Open-drain bus: a line is low if either side pulls it low.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ        (CLK_HZ),
        .INHIBIT_US    (INHIBIT_US),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1)  err_cnt++;
        if (tx_done === 1'b1 && tx_err === 1'b1) both_seen = 1'b1;
    end

    // Reference frame as the device should see it: bit 0 start, bits 1..8
    // data LSB first, bit 9 odd parity, bit 10 stop.
    function automatic logic [10:0] expected_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (scramble) tx_data = 8'($urandom);
    endtask

    // Behavioural device: waits for the request, measures the inhibit, then
    // generates nfalls clock pulses, sampling data just before each rise.
    task automatic device(input int half, input bit ack, input int nfalls,
                          output logic [10:0] frame, output int inh_len,
                          output bit last_inh_doe, output bit ok);
        int n;
        frame        = '1;
        inh_len      = 0;
        last_inh_doe = 1'b0;
        ok           = 1'b1;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 20) begin tick(); n++; end
        if (ps2_clk_oe !== 1'b1) begin ok = 1'b0; return; end
        while (ps2_clk_oe === 1'b1 && inh_len < INH_N + 100) begin
            last_inh_doe = ps2_data_oe;
            inh_len++;
            tick();
        end
        frame[0] = ps2_data_in;
        repeat (half) tick();
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11) begin
                dev_data = ack ? 1'b0 : 1'b1;
                repeat (3) tick();
            end
            dev_clk = 1'b0;
            repeat (half) tick();
            if (i <= 10) frame[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (half) tick();
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin tick(); n++; end
        ok = (tx_ready === 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack,
                             output logic [10:0] frame, output int inh_len,
                             output bit last_doe, output bit ok);
        bit ok_dev, ok_rdy;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        device($urandom_range(30, 60), ack, 11, frame, inh_len, last_doe, ok_dev);
        wait_ready(ok_rdy);
        ok = ok_dev && ok_rdy;
    endtask

    task automatic test_reset();
        tick();
        #2;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 ||
            ps2_data_oe !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b busy=%b clk_oe=%b data_oe=%b done=%b err=%b, need 1 0 0 0 0 0",
                     tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err);
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: ready=%b busy=%b clk_oe=%b data_oe=%b, need 1 0 0 0",
                     tx_ready, busy, ps2_clk_oe, ps2_data_oe);
        end
        $display("reset: ready=%b busy=%b", tx_ready, busy);
    endtask

    task automatic check_frame(input string name, input logic [7:0] d, input bit ack,
                               input int done_need);
        logic [10:0] frame;
        int inh, d0, e0;
        bit last, ok;
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(d, ack, frame, inh, last, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_handshake: device or ready wait timed out", name); end
        checks++;
        if (inh != INH_N) begin failures++; $display("FAIL %s_inhibit_len: got %0d need %0d", name, inh, INH_N); end
        checks++;
        if (last !== 1'b1) begin failures++; $display("FAIL %s_data_before_release: got %b need 1", name, last); end
        checks++;
        if (frame !== expected_frame(d)) begin
            failures++;
            $display("FAIL %s_frame: byte %02h got %011b need %011b", name, d, frame, expected_frame(d));
        end
        checks++;
        if (done_cnt - d0 != done_need || err_cnt - e0 != 1 - done_need) begin
            failures++;
            $display("FAIL %s_pulses: done=%0d err=%0d need done=%0d err=%0d",
                     name, done_cnt - d0, err_cnt - e0, done_need, 1 - done_need);
        end
        $display("%s: byte=%02h frame=%011b inhibit=%0d done=%0d err=%0d",
                 name, d, frame, inh, done_cnt - d0, err_cnt - e0);
    endtask

    task automatic test_basic();
        check_frame("basic", 8'hED, 1'b1, 1);
    endtask

    task automatic test_parity();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h01};
        logic       pbits [3] = '{1'b1, 1'b1, 1'b0};
        logic [10:0] frame;
        int inh;
        bit last, ok;
        for (int i = 0; i < 3; i++) begin
            run_frame(bytes[i], 1'b1, frame, inh, last, ok);
            checks++;
            if (!ok || frame[9] !== pbits[i]) begin
                failures++;
                $display("FAIL parity_fixed: byte %02h ok=%b parity %b need %b", bytes[i], ok, frame[9], pbits[i]);
            end
            $display("parity: byte=%02h parity=%b", bytes[i], frame[9]);
        end
        for (int i = 0; i < 4; i++) check_frame("random", 8'($urandom), 1'b1, 1);
    endtask

    task automatic test_nack();
        check_frame("nack", 8'($urandom), 1'b0, 0);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL nack_release: clk_oe=%b data_oe=%b ready=%b need 0 0 1",
                     ps2_clk_oe, ps2_data_oe, tx_ready);
        end
    endtask

    task automatic test_timeout();
        int n = 0, k = 0, err_k = -1, e0;
        bit oe_at_err = 1'b1;
        e0 = err_cnt;
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        while (ps2_clk_oe === 1'b1 && n < INH_N + 100) begin tick(); n++; end
        while (tx_ready !== 1'b1 && k < TIMEOUT_CYCLES + 50) begin
            if (tx_err === 1'b1) begin
                err_k = k;
                oe_at_err = ps2_clk_oe | ps2_data_oe;
            end
            tick();
            k++;
        end
        checks++;
        if (k != TIMEOUT_CYCLES) begin
            failures++;
            $display("FAIL timeout_idle: idle after %0d cycles need %0d", k, TIMEOUT_CYCLES);
        end
        checks++;
        if (err_k != TIMEOUT_CYCLES - 1 || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL timeout_err: err at %0d count %0d need at %0d count 1",
                     err_k, err_cnt - e0, TIMEOUT_CYCLES - 1);
        end
        checks++;
        if (oe_at_err !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release: oe at err=%b clk_oe=%b data_oe=%b need 0",
                     oe_at_err, ps2_clk_oe, ps2_data_oe);
        end
        $display("timeout: idle after %0d cycles, err at %0d", k, err_k);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic [10:0] f1, f2;
        int inh, d0;
        bit last, ok1, ok2, okr;
        a = 8'($urandom);
        b = 8'($urandom);
        d0 = done_cnt;
        tx_data  = a;
        tx_valid = 1'b1;
        scramble = 1'b1;
        device($urandom_range(30, 60), 1'b1, 11, f1, inh, last, ok1);
        wait_ready(okr);
        scramble = 1'b0;
        tx_data  = b;
        device($urandom_range(30, 60), 1'b1, 11, f2, inh, last, ok2);
        tx_valid = 1'b0;
        wait_ready(okr);
        checks++;
        if (!ok1 || f1 !== expected_frame(a)) begin
            failures++;
            $display("FAIL bp_first: got %011b need %011b", f1, expected_frame(a));
        end
        checks++;
        if (!ok2 || !okr || f2 !== expected_frame(b)) begin
            failures++;
            $display("FAIL bp_second: got %011b need %011b", f2, expected_frame(b));
        end
        checks++;
        if (done_cnt - d0 != 2) begin
            failures++;
            $display("FAIL bp_done_count: got %0d need 2", done_cnt - d0);
        end
        $display("back_to_back: first=%02h second=%02h done=%0d", a, b, done_cnt - d0);
    endtask

    task automatic test_reset_mid();
        logic [10:0] frame;
        int inh;
        bit last, ok;
        tx_data  = 8'hE5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        device(40, 1'b1, 5, frame, inh, last, ok);
        checks++;
        if (!ok || ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_before_reset: data_oe=%b busy=%b need 1 1", ps2_data_oe, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_reset: clk_oe=%b data_oe=%b ready=%b busy=%b need 0 0 1 0",
                     ps2_clk_oe, ps2_data_oe, tx_ready, busy);
        end
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        $display("reset_mid: lines released, ready=%b", tx_ready);
        check_frame("after_reset", 8'hF4, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (both_seen) begin
            failures++;
            $display("FAIL done_err_exclusive: both pulses high together");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
